// File: rtl/prio_decoder_seq.sv
// prio_decoder_seq: registered SEL_W-to-2**SEL_W one-hot decoder with DIRECT, SCAN (walking one) and PULSE (one-shot) modes.
// Latency: one clock from inputs to y/idx/valid/busy. No backpressure; mode, en and start are sampled at every clock edge.
// Optional macro PRIO_DEC_SCAN_MASK_EN adds a scan_mask input. A mask bit of 1 makes SCAN skip that index.
module prio_decoder_seq #(
  parameter int SEL_W       = 2,
  parameter int OUT_W       = 2**SEL_W,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             start,
`ifdef PRIO_DEC_SCAN_MASK_EN
  input  logic [OUT_W-1:0] scan_mask,
`endif
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_PULSE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  // These hold the scan entry index and the next scan index, plus flags for whether an unmasked index exists.
  logic [SEL_W-1:0] first_idx, next_idx;
  logic             first_found, next_found;
  state_t           target;
  logic             entering;

`ifdef PRIO_DEC_SCAN_MASK_EN
  logic [SEL_W-1:0] cand;

  // Find the lowest unmasked index for SCAN entry.
  // Find the next unmasked index after idx_q, with wrap.
  // The descending loops leave the nearest hit in place.
  always_comb begin
    first_idx   = '0;
    first_found = 1'b0;
    next_idx    = '0;
    next_found  = 1'b0;
    cand        = '0;
    for (int i = OUT_W - 1; i >= 0; i--) begin
      if (!scan_mask[i]) begin
        first_found = 1'b1;
        first_idx   = SEL_W'(i);
      end
    end
    // When i equals OUT_W, the index wraps back to idx_q. A single unmasked index therefore keeps being selected.
    for (int i = OUT_W; i >= 1; i--) begin
      cand = idx_q + SEL_W'(i);
      if (!scan_mask[cand]) begin
        next_found = 1'b1;
        next_idx   = cand;
      end
    end
  end
`else
  // With no mask, the scan enters at index 0 and steps through every index.
  always_comb begin
    first_idx   = '0;
    first_found = 1'b1;
    next_idx    = idx_q + SEL_W'(1);
    next_found  = 1'b1;
  end
`endif

  // Next-state and output logic. en has priority, then mode. Any change of state restarts the sequence.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;

    if (!en) begin
      target = ST_IDLE;
    end else begin
      case (mode)
        2'b00:   target = ST_DIRECT;
        2'b01:   target = ST_SCAN;
        2'b10:   target = ST_PULSE;
        default: target = ST_IDLE;
      endcase
    end
    state_d  = target;
    entering = (target != state_q);

    case (target)
      ST_DIRECT: begin
        cnt_d   = '0;
        idx_d   = sel;
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
      ST_SCAN: begin
        busy_d = 1'b1;
        if (entering) begin
          cnt_d   = '0;
          idx_d   = first_idx;
          valid_d = first_found;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = next_idx;
          valid_d = next_found;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (!entering && busy_q) begin
          // A pulse is running. It ends after HOLD_CYCLES clocks, and start is ignored while it runs.
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (start && !busy_q) begin
          cnt_d   = '0;
          idx_d   = sel;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          cnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // y is always derived from idx and valid. This keeps y one-hot, or zero when valid is low.
    y_d = valid_d ? ({{(OUT_W-1){1'b0}}, 1'b1} << idx_d) : '0;
  end

  // State and output registers, with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_prio_decoder_seq.sv
// Directed bench for prio_decoder_seq with SEL_W=2. The main instance uses HOLD_CYCLES=3 and a second instance uses HOLD_CYCLES=1.
// Expected outputs are queued when stimulus is driven. They are popped and compared one clock later, or immediately for async reset.
module tb_prio_decoder_seq;

  typedef struct packed {
    logic [3:0] y;
    logic [1:0] idx;
    logic       valid;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [1:0] sel;
  logic       start;
  logic [3:0] y, y1;
  logic [1:0] idx, idx1;
  logic       valid, valid1;
  logic       busy, busy1;
`ifdef PRIO_DEC_SCAN_MASK_EN
  logic [3:0] scan_mask;
`endif

  exp_t q[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  prio_decoder_seq #(.SEL_W(2), .HOLD_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .start(start),
`ifdef PRIO_DEC_SCAN_MASK_EN
    .scan_mask(scan_mask),
`endif
    .y(y), .idx(idx), .valid(valid), .busy(busy)
  );

  prio_decoder_seq #(.SEL_W(2), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .start(start),
`ifdef PRIO_DEC_SCAN_MASK_EN
    .scan_mask(scan_mask),
`endif
    .y(y1), .idx(idx1), .valid(valid1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [3:0] ey, input logic [1:0] ei, input logic ev, input logic eb);
    mk = '{y: ey, idx: ei, valid: ev, busy: eb};
  endfunction

  function automatic exp_t on(input int i, input logic eb);
    logic [3:0] one;
    one = 4'b0001;
    on = mk(one << i, 2'(i), 1'b1, eb);
  endfunction

  task automatic check(input string tag);
    exp_t e, o;
    e = q.pop_front();
    o = '{y: y, idx: idx, valid: valid, busy: busy};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got y=%b idx=%0d valid=%b busy=%b, want y=%b idx=%0d valid=%b busy=%b",
             tag, o.y, o.idx, o.valid, o.busy, e.y, e.idx, e.valid, e.busy);
    end
  endtask

  task automatic check1(input string tag);
    exp_t e, o;
    e = q1.pop_front();
    o = '{y: y1, idx: idx1, valid: valid1, busy: busy1};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got y=%b idx=%0d valid=%b busy=%b, want y=%b idx=%0d valid=%b busy=%b",
             tag, o.y, o.idx, o.valid, o.busy, e.y, e.idx, e.valid, e.busy);
    end
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [1:0] s, input logic st, input exp_t ex);
    en = e; mode = m; sel = s; start = st;
    q.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic e, input logic [1:0] m, input logic [1:0] s, input logic st, input exp_t ex, input string tag);
    drive(e, m, s, st, ex);
    check(tag);
  endtask

  exp_t ZERO;

  initial begin
    ZERO = mk(4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b1; en = 1'b0; mode = 2'b00; sel = 2'd0; start = 1'b0;
`ifdef PRIO_DEC_SCAN_MASK_EN
    scan_mask = 4'b0000;
`endif
    #2;
    q.push_back(ZERO);
    check("reset_state");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Direct decode with one-clock latency, then disable.
    step(1, 2'b00, 2'd2, 0, on(2, 0), "direct_sel2");
    step(1, 2'b00, 2'd3, 0, on(3, 0), "direct_sel3");
    step(0, 2'b00, 2'd3, 0, ZERO, "direct_en_off");

    // Scan with a dwell of 3 clocks per index. It returns to index 0 after 12 clocks.
    // sel and start are randomised here to show that scan ignores them.
    // The HOLD_CYCLES=1 instance advances every clock.
    for (int k = 0; k < 13; k++) begin
      q1.push_back(on(k % 4, 1));
      step(1, 2'b01, 2'($urandom), 1'($urandom), on((k / 3) % 4, 1), "scan_walk");
      check1("scan_walk_h1");
    end

    // Switch from scan to direct while the scan is at index 2.
    step(0, 2'b01, 2'd0, 0, ZERO, "scan_stop");
    for (int k = 0; k < 7; k++)
      step(1, 2'b01, 2'd1, 0, on((k / 3) % 4, 1), "scan_to_idx2");
    step(1, 2'b00, 2'd0, 0, on(0, 0), "scan_to_direct");
    for (int k = 0; k < 4; k++)
      step(1, 2'b01, 2'd0, 0, on(k / 3, 1), "rescan_full_dwell");

    // Pulse mode. It is idle on entry from direct mode.
    step(1, 2'b10, 2'd1, 0, ZERO, "pulse_idle");
    q1.push_back(on(1, 1));
    step(1, 2'b10, 2'd1, 1, on(1, 1), "pulse_launch");
    check1("pulse_launch_h1");
    q1.push_back(ZERO);
    step(1, 2'b10, 2'd3, 1, on(1, 1), "pulse_retrigger_ignored");
    check1("pulse_end_h1");
    step(1, 2'b10, 2'd3, 0, on(1, 1), "pulse_hold3");
    step(1, 2'b10, 2'd2, 1, ZERO, "pulse_end_start_ignored");
    step(1, 2'b10, 2'd2, 0, ZERO, "pulse_no_extra");
    step(1, 2'b10, 2'd3, 1, on(3, 1), "pulse2_launch");
    step(1, 2'b10, 2'd0, 0, on(3, 1), "pulse2_hold2");
    step(1, 2'b10, 2'd0, 0, on(3, 1), "pulse2_hold3");
    step(1, 2'b10, 2'd0, 0, ZERO, "pulse2_end");

    // A mode change aborts a running pulse. Reserved mode 11 is treated as idle.
    step(1, 2'b10, 2'd2, 1, on(2, 1), "pulse3_launch");
    step(1, 2'b01, 2'd2, 0, on(0, 1), "pulse_abort_to_scan");
    step(1, 2'b11, 2'd2, 1, ZERO, "mode11_idle");

    // Asynchronous reset in the middle of a scan clears outputs without a clock edge.
    step(1, 2'b01, 2'd0, 0, on(0, 1), "scan_pre_reset0");
    for (int k = 1; k < 5; k++)
      step(1, 2'b01, 2'd0, 0, on(k / 3, 1), "scan_pre_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    q.push_back(ZERO);
    check("async_reset");
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++)
      step(1, 2'b01, 2'd0, 0, on(k / 3, 1), "scan_after_reset");

`ifdef PRIO_DEC_SCAN_MASK_EN
    // With the mask, the scan visits only the unmasked indices 1 and 3.
    step(0, 2'b01, 2'd0, 0, ZERO, "mask_stop");
    scan_mask = 4'b0101;
    for (int k = 0; k < 7; k++)
      step(1, 2'b01, 2'd0, 0, on(((k / 3) % 2) * 2 + 1, 1), "mask_0101");
    step(0, 2'b01, 2'd0, 0, ZERO, "mask_stop2");
    scan_mask = 4'b1111;
    step(1, 2'b01, 2'd0, 0, mk(4'b0000, 2'd0, 1'b0, 1'b1), "mask_all");
    step(1, 2'b01, 2'd0, 0, mk(4'b0000, 2'd0, 1'b0, 1'b1), "mask_all_hold");
    scan_mask = 4'b0000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_decoder_seq.md
Name: prio_decoder_seq

Overview:
Parametrised, registered successor to the team's 2-to-4 enable decoder. It generalises to SEL_W-to-2^SEL_W one-hot decode and adds sequential modes: direct registered decode, an auto-scan walking one, and a timed one-shot pulse. It drives one-hot select lines, such as LED and digit strobes, mux enables and chip selects, in the lab datapaths.

Parameters:
SEL_W, 2, select width; the output count is 2**SEL_W.
OUT_W, 2**SEL_W, output width; derived from SEL_W and must not be overridden.
HOLD_CYCLES, 4, dwell length in clocks per output in SCAN mode and pulse length in PULSE mode; must be >= 1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-high.
en  input  1  block enable; low forces outputs to zero on the next edge.
mode  input  2  00 DIRECT, 01 SCAN, 10 PULSE, 11 reserved (treated as idle).
sel  input  SEL_W  select index, used in DIRECT and PULSE modes.
start  input  1  one-cycle strobe that launches a pulse in PULSE mode.
y  output  OUT_W  registered one-hot output; all zero when inactive.
idx  output  SEL_W  registered index of the currently asserted bit.
valid  output  1  high exactly when y is non-zero.
busy  output  1  high while a SCAN or PULSE sequence is running.

Behaviour:
- Reset (async, active-high) sets y=0, idx=0, valid=0, busy=0, the dwell counter to 0 and the FSM to IDLE, all immediately.
- FSM states: IDLE, DIRECT, SCAN, PULSE. All outputs are registered, and the invariant y == (valid ? 1<<idx : 0) holds in every cycle.
- en=0 at an edge: go to IDLE, with y=0, valid=0, busy=0 and the counter cleared. en has priority over mode and start.
- Mode 11 with en=1: behaves as IDLE.
- Mode is sampled at every edge. Any change of mode takes effect at that edge: the counter clears and a running SCAN or PULSE aborts without completing.
- DIRECT: at each edge, y <= 1<<sel and idx <= sel, with valid=1 and busy=0. Latency is 1 clock; a sel change appears on y at the following edge.
- SCAN, on entry: idx=0, y=0...01, valid=1, busy=1.
- SCAN, dwell: each index is held exactly HOLD_CYCLES clocks. Then idx increments and wraps from OUT_W-1 to 0. The full period is OUT_W*HOLD_CYCLES clocks. sel and start are ignored.
- PULSE, idle: y=0, valid=0, busy=0.
- PULSE, launch: start=1 while busy=0 captures sel. At the next edge, y=1<<sel, valid=1, busy=1.
- PULSE, duration: y stays high for exactly HOLD_CYCLES clocks, then y=0, valid=0 and busy=0 on the same edge.
- PULSE, retrigger: start while busy=1 is ignored. start on the same edge as the final pulse cycle is also ignored, because busy is still 1.
- Counter: width $clog2(HOLD_CYCLES+1). With HOLD_CYCLES=1, the scan advances every clock and a pulse lasts one clock.

Optional Feature:
Macro PRIO_DEC_SCAN_MASK_EN.
- Defined: adds an input scan_mask [OUT_W-1:0], where 1 means skip that index.
  - SCAN steps only through unmasked indices, in ascending order with wrap. It takes the next unmasked index after the dwell and enters at the lowest unmasked index.
  - If all bits are masked: y=0, valid=0, busy=1.
  - A mask change applies at the next index advance.
- Undefined: the port is absent and every index is scanned.

Test Plan:
1. Reset: with SEL_W=2, assert rst mid-SCAN -> y=0000, idx=0, valid=0 and busy=0 immediately, without a clock edge.
2. DIRECT: en=1, mode=00, sel=2 -> y=0100, idx=2, valid=1 one edge later. Then sel=3 -> y=1000 on the next edge. en=0 -> y=0000 on the next edge.
3. SCAN: HOLD_CYCLES=3, mode=01 -> y steps 0001, 0010, 0100, 1000, 3 clocks each. It returns to 0001 at clock 12, and busy=1 throughout.
4. PULSE: HOLD_CYCLES=3, mode=10, start=1 with sel=1 -> y=0010 for exactly 3 clocks, then y=0000 and busy=0. A second start issued during the pulse produces no extra cycles.
5. Mode change mid-sequence: switch SCAN to DIRECT at idx=2 with sel=0 -> y=0001 at the next edge, busy=0, and the counter cleared.
6. With PRIO_DEC_SCAN_MASK_EN: scan_mask=0101 -> the scan visits only 0010 and 1000. scan_mask=1111 -> y=0000, valid=0, busy=1.
